// File: rtl/freq_divider_by2.sv
// Divide-by-two clock generator: one toggle flop whose output is the divided clock.
// clk_out is a fabric signal; route it through a clock buffer or use it as an enable.
module freq_divider_by2 #(
    parameter logic INIT_VAL = 1'b0,
    parameter logic RST_VAL  = 1'b0
) (
    input  logic clk,
    input  logic rst,
    output logic clk_out
);

    // Declaration initialiser gives a known power-up value in simulation and an FPGA init value.
    logic div_q = INIT_VAL;
    logic div_d;

    always_comb begin
        div_d = ~div_q;
        if (rst) begin
            div_d = RST_VAL;
        end
    end

    always_ff @(posedge clk) begin
        div_q <= div_d;
    end

    assign clk_out = div_q;

endmodule

// File: tb/tb_freq_divider_by2.sv
// Bench for freq_divider_by2: directed reset/phase steps, then randomized reset
// traffic against a parity-of-edges-since-reset reference.
module tb_freq_divider_by2;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic clk_out;

    int unsigned vectors     = 0;
    int unsigned miscompares = 0;

    // Reference: output equals the parity of rising edges seen since the last reset edge.
    int unsigned edges_since_rst = 0;
    logic        prev_out        = 1'b0;
    time         last_rise       = 0;
    time         last_fall       = 0;
    time         rise_period     = 0;
    time         high_time       = 0;

    freq_divider_by2 #(
        .INIT_VAL(1'b0),
        .RST_VAL (1'b0)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .clk_out(clk_out)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        vectors++;
        assert (observed === expected) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h at %0t", tag, observed, expected, $time);
        end
    endtask

    function automatic logic model_out();
        return logic'(edges_since_rst % 2 == 1);
    endfunction

    task automatic note_edge(input logic r);
        if (r) edges_since_rst = 0;
        else   edges_since_rst++;
    endtask

    // One clock: drive rst at the falling edge, optionally glitch it high between edges,
    // then check the output 1 ns after the rising edge.
    task automatic step(input logic r, input logic glitch, input string tag);
        logic held;
        @(negedge clk);
        rst = r;
        if (glitch && !r) begin
            held = clk_out;
            #1 rst = 1'b1;
            #2;
            check("glitch_no_effect", 32'(clk_out), 32'(held));
            rst = 1'b0;
        end
        @(posedge clk);
        #1;
        note_edge(r);
        check(tag, 32'(clk_out), 32'(model_out()));
        if (!prev_out && clk_out === 1'b1) begin
            if (last_rise != 0) rise_period = $time - last_rise;
            last_rise = $time;
        end
        if (prev_out && clk_out === 1'b0) begin
            last_fall = $time;
            high_time = last_fall - last_rise;
        end
        prev_out = clk_out;
    endtask

    initial begin
        int unsigned rises;
        logic        seen_x;

        // Power-up value before any clock edge.
        #1;
        check("power_up", 32'(clk_out), 32'(1'b0));

        // First edge at 5 ns with rst low: 0 -> 1.
        @(posedge clk);
        #1;
        note_edge(1'b0);
        check("first_edge", 32'(clk_out), 32'(1'b1));
        prev_out = clk_out;

        // Reset asserted at 10 ns and held through the 105 ns edge.
        for (int i = 0; i < 10; i++) step(1'b1, 1'b0, "held_reset");

        // Released at 110 ns: 1, 0, 1 on the following edges.
        step(1'b0, 1'b0, "release_e1");
        check("release_e1_abs", 32'(clk_out), 32'(1'b1));
        step(1'b0, 1'b0, "release_e2");
        check("release_e2_abs", 32'(clk_out), 32'(1'b0));
        step(1'b0, 1'b0, "release_e3");
        check("release_e3_abs", 32'(clk_out), 32'(1'b1));
        check("period_ns", 32'(rise_period), 32'd20);
        check("high_ns", 32'(high_time), 32'd10);

        // Three-cycle reset then release.
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, "reset3");
        step(1'b0, 1'b0, "after_reset3");
        check("after_reset3_abs", 32'(clk_out), 32'(1'b1));

        // Single-edge reset while high drops to 0, then resumes toggling.
        step(1'b1, 1'b0, "reset_while_high");
        check("reset_while_high_abs", 32'(clk_out), 32'(1'b0));
        step(1'b0, 1'b0, "resume");
        check("resume_abs", 32'(clk_out), 32'(1'b1));

        // Reset pulse entirely between edges is ignored.
        step(1'b0, 1'b1, "glitch_then_edge");
        step(1'b0, 1'b1, "glitch_then_edge");

        // Free run for 1000 edges: exactly 500 rising edges, never X.
        rises  = 0;
        seen_x = 1'b0;
        for (int i = 0; i < 1000; i++) begin
            @(posedge clk);
            #1;
            note_edge(1'b0);
            if ($isunknown(clk_out)) seen_x = 1'b1;
            if (!prev_out && clk_out === 1'b1) rises++;
            prev_out = clk_out;
        end
        check("freerun_rises", 32'(rises), 32'd500);
        check("freerun_no_x", 32'(seen_x), 32'd0);
        check("freerun_phase", 32'(clk_out), 32'(model_out()));

        // Randomized reset traffic with occasional between-edge glitches.
        for (int i = 0; i < 300; i++) begin
            step(logic'($urandom_range(0, 3) == 0), logic'($urandom_range(0, 4) == 0), "random");
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    // Watchdog: the sequence above is bounded, but never allow a hang.
    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
